// File: rtl/imem_responder.sv
// Instruction-memory responder: fetch-port slave with fixed read latency,
// in-order response FIFO and credit-limited outstanding requests.
module imem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter int          FIFO_DEPTH  = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_flush,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_data,
   output logic [31:0] o_rsp_addr,
   output logic        o_rsp_err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] addr;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   logic [31:0]   mem [DEPTH_WORDS];
   rsp_t          fq  [FIFO_DEPTH];
   logic [CW-1:0] cnt;
   logic [CW-1:0] occ;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [29:0]   idx;
   logic          req_err;
   logic          accept;
   logic          push;
   logic          fifo_push;
   logic          pop;
   logic          nonempty;
   logic          fifo_full;
   rsp_t          acc_b;
   rsp_t          push_b;
   rsp_t          head;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Word index relative to BASE_ADDR (BASE_ADDR is word aligned).
   assign idx     = i_req_addr[31:2] - BASE_ADDR[31:2];
   assign req_err = (i_req_addr[1:0] != 2'b00) | (idx >= 30'(DEPTH_WORDS));

   assign o_req_ready = (cnt < CW'(FIFO_DEPTH)) & ~i_flush;
   assign accept      = i_req_valid & o_req_ready;
   assign nonempty    = (occ != '0);
   assign fifo_full   = (occ == CW'(FIFO_DEPTH));
   assign o_rsp_valid = nonempty & ~i_flush;
   assign pop         = o_rsp_valid & i_rsp_ready;
   assign fifo_push   = push & ~i_flush;

   // Build the response bundle for the request being accepted now.
   always_comb begin
      acc_b      = '0;
      acc_b.addr = i_req_addr;
      acc_b.err  = req_err;
      acc_b.data = req_err ? NOP : mem[idx[AW-1:0]];
   end

   generate
      if (LATENCY == 1) begin : gen_lat1
         assign push   = accept;
         assign push_b = acc_b;
      end else begin : gen_pipe
         logic [LATENCY-2:0] pv;
         rsp_t               pb [LATENCY-1];

         // Valid bits of the read pipeline, cleared by flush.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               pv <= '0;
            end else if (i_flush) begin
               pv <= '0;
            end else begin
               pv[0] <= accept;
               for (int k = 1; k < LATENCY - 1; k++) pv[k] <= pv[k-1];
            end
         end

         // Payload of the read pipeline, qualified by pv.
         always_ff @(posedge clk) begin
            pb[0] <= acc_b;
            for (int k = 1; k < LATENCY - 1; k++) pb[k] <= pb[k-1];
         end

         assign push   = pv[LATENCY-2];
         assign push_b = pb[LATENCY-2];
      end
   endgenerate

   // Credit counter, FIFO occupancy and pointers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt    <= '0;
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (i_flush) begin
         cnt    <= '0;
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         cnt <= cnt + CW'(accept) - CW'(pop);
         occ <= occ + CW'(push) - CW'(pop);
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
      end
   end

   // Response storage; entries are only meaningful below occ.
   always_ff @(posedge clk) begin
      if (fifo_push) fq[wr_ptr] <= push_b;
   end

   // Credits must keep the FIFO from ever being overrun.
   always @(posedge clk) begin
      if (rstn && fifo_push) assert (!fifo_full);
   end

   assign head       = fq[rd_ptr];
   assign o_rsp_data = nonempty ? head.data : '0;
   assign o_rsp_addr = nonempty ? head.addr : '0;
   assign o_rsp_err  = nonempty ? head.err  : 1'b0;

endmodule
